// File: rtl/ram_axi_rd_if.sv
// AXI read-channel bundle (AR + R) between a read master and ram_axi_rd.
// The master modport drives the request and RREADY; the slave modport
// drives ARREADY and the R beat.
interface ram_axi_rd_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int ID_WIDTH   = 4
) ();

   logic [ID_WIDTH-1:0]   ARID;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [1:0]            ARBURST;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [ID_WIDTH-1:0]   RID;
   logic [BYTE_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

   modport slave (
      input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
      output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
   );

endinterface

// File: rtl/ram_axi_rd.sv
// AXI read slave in front of a synchronous byte RAM (one byte per beat).
// A burst is accepted in IDLE, then addresses are issued one per cycle while
// the 2-entry output buffer plus the single in-flight RAM read leave room.
// The RAM answers one cycle after the address; the answer is pushed into the
// buffer tagged with id/last/resp and the buffer head drives the R channel.
module ram_axi_rd #(
   parameter int ADDR_WIDTH = 16,
   parameter int BYTE_WIDTH = 8,
   parameter int ID_WIDTH   = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   ram_axi_rd_if.slave           axi,
   output logic [ADDR_WIDTH-1:0] raddr,
   input  logic [BYTE_WIDTH-1:0] rdata
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_t;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // A request is in error for any beat size other than one byte or for the
   // reserved burst encoding.
   function automatic logic ar_error(input logic [2:0] size, input logic [1:0] burst);
      ar_error = (size != 3'd0) || (burst == BURST_RSVD);
   endfunction

   // Address of the following beat. For WRAP the length (1, 3, 7 or 15) is
   // also the low-bit mask of the aligned window, so only those bits advance.
   function automatic logic [ADDR_WIDTH-1:0] next_addr(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic [1:0]            mode,
      input logic [7:0]            len
   );
      logic [ADDR_WIDTH-1:0] inc;
      logic [ADDR_WIDTH-1:0] mask;
      inc  = addr + ADDR_WIDTH'(1'b1);
      mask = ADDR_WIDTH'(len);
      case (mode)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
         default:     next_addr = inc;
      endcase
   endfunction

   state_t                state_r;
   state_t                state_next_s;

   logic                  ar_hs_s;
   logic                  pop_s;
   logic                  push_s;
   logic                  issue_s;
   logic [2:0]            level_s;

   // burst context latched at the AR handshake
   logic [ID_WIDTH-1:0]   id_r;
   logic [ADDR_WIDTH-1:0] addr_r;
   logic [7:0]            len_r;
   logic [7:0]            cnt_r;
   logic [1:0]            mode_r;
   logic                  err_r;

   logic [ADDR_WIDTH-1:0] raddr_hold_r;

   // tags of the RAM read whose data arrives this cycle
   logic                  inflight_r;
   logic [ID_WIDTH-1:0]   infl_id_r;
   logic                  infl_last_r;
   logic                  infl_err_r;

   // 2-entry in-order output buffer
   logic [1:0][BYTE_WIDTH-1:0] buf_data_r;
   logic [1:0][ID_WIDTH-1:0]   buf_id_r;
   logic [1:0]                 buf_last_r;
   logic [1:0][1:0]            buf_resp_r;
   logic                       wr_ptr_r;
   logic                       rd_ptr_r;
   logic [1:0]                 occ_r;

   assign ar_hs_s = axi.ARVALID && (state_r == IDLE);
   assign pop_s   = (occ_r != 2'd0) && axi.RREADY;
   assign push_s  = inflight_r;
   // occupancy the buffer will have once this cycle's push and pop settle
   assign level_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};

   // Next state and address-issue decision.
   always_comb begin
      state_next_s = state_r;
      issue_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (ar_hs_s) begin
               state_next_s = BURST;
            end else begin
               state_next_s = IDLE;
            end
         end
         BURST: begin
            if (level_s < 3'd2) begin
               issue_s = 1'b1;
               if (cnt_r == len_r) begin
                  state_next_s = IDLE;
               end else begin
                  state_next_s = BURST;
               end
            end else begin
               state_next_s = BURST;
            end
         end
         default: begin
            state_next_s = IDLE;
            issue_s      = 1'b0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Latch the burst at the handshake, then walk the address per issued beat.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         id_r   <= '0;
         addr_r <= '0;
         len_r  <= 8'd0;
         cnt_r  <= 8'd0;
         mode_r <= BURST_INCR;
         err_r  <= 1'b0;
      end else if (ar_hs_s) begin
         id_r   <= axi.ARID;
         addr_r <= axi.ARADDR;
         len_r  <= axi.ARLEN;
         cnt_r  <= 8'd0;
         err_r  <= ar_error(axi.ARSIZE, axi.ARBURST);
         mode_r <= ar_error(axi.ARSIZE, axi.ARBURST) ? BURST_INCR : axi.ARBURST;
      end else if (issue_s) begin
         addr_r <= next_addr(addr_r, mode_r, len_r);
         cnt_r  <= cnt_r + 8'd1;
      end
   end

   // The RAM address follows the issued beat and otherwise keeps its value.
   assign raddr = issue_s ? addr_r : raddr_hold_r;

   // Remember the last issued address so raddr holds between issues.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         raddr_hold_r <= '0;
      end else if (issue_s) begin
         raddr_hold_r <= addr_r;
      end
   end

   // Carry the issued beat's tags alongside the one-cycle RAM read.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         inflight_r  <= 1'b0;
         infl_id_r   <= '0;
         infl_last_r <= 1'b0;
         infl_err_r  <= 1'b0;
      end else begin
         inflight_r <= issue_s;
         if (issue_s) begin
            infl_id_r   <= id_r;
            infl_last_r <= (cnt_r == len_r);
            infl_err_r  <= err_r;
         end
      end
   end

   // Output buffer: push returning RAM data, pop on R handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         buf_data_r <= '0;
         buf_id_r   <= '0;
         buf_last_r <= 2'b00;
         buf_resp_r <= '0;
         wr_ptr_r   <= 1'b0;
         rd_ptr_r   <= 1'b0;
         occ_r      <= 2'd0;
      end else begin
         if (push_s) begin
            buf_data_r[wr_ptr_r] <= rdata;
            buf_id_r[wr_ptr_r]   <= infl_id_r;
            buf_last_r[wr_ptr_r] <= infl_last_r;
            buf_resp_r[wr_ptr_r] <= infl_err_r ? RESP_SLVERR : RESP_OKAY;
            wr_ptr_r             <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

   assign axi.ARREADY = (state_r == IDLE);
   assign axi.RVALID  = (occ_r != 2'd0);
   assign axi.RID     = buf_id_r[rd_ptr_r];
   assign axi.RDATA   = buf_data_r[rd_ptr_r];
   assign axi.RLAST   = buf_last_r[rd_ptr_r];
   assign axi.RRESP   = buf_resp_r[rd_ptr_r];

endmodule

// File: tb/tb_ram_axi_rd.sv
// Bench for ram_axi_rd: a byte RAM model, an AR driver that predicts every
// beat of each accepted burst from the addressing rules, an R monitor that
// scores every accepted beat and checks hold-stability under back-pressure,
// plus directed sequences with literal expectations.
module tb_ram_axi_rd;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] raddr;
   logic [7:0]  rdata;

   ram_axi_rd_if #(.ADDR_WIDTH(16), .BYTE_WIDTH(8), .ID_WIDTH(4)) axi ();

   ram_axi_rd #(.ADDR_WIDTH(16), .BYTE_WIDTH(8), .ID_WIDTH(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .axi   (axi),
      .raddr (raddr),
      .rdata (rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] id;
      logic [7:0] data;
      logic       last;
      logic [1:0] resp;
   } beat_t;

   beat_t      exp_q[$];
   beat_t      got_q[$];
   logic [7:0] mem [0:65535];
   int         checks = 0;
   int         errors = 0;
   int         beats_acc = 0;
   int         rr_mode = 0;

   // synchronous byte RAM
   always @(posedge clk) rdata <= mem[raddr];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, got, exp);
      end
   endtask

   // byte address of beat k of a burst, straight from the addressing rules
   function automatic logic [15:0] beat_addr(input logic [15:0] a, input logic [7:0] len,
                                             input logic [1:0] bt, input int k);
      int unsigned w, base;
      case (bt)
         2'b00: return a;
         2'b10: begin
            w    = int'(len) + 1;
            base = (int'(a) / w) * w;
            return 16'(base + ((int'(a) - base + k) % w));
         end
         default: return 16'(int'(a) + k);
      endcase
   endfunction

   // issue one AR, wait for acceptance, and queue the predicted beats
   task automatic ar_send(input logic [3:0] id, input logic [15:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
      int    n;
      logic  err;
      beat_t b;
      n = 0;
      @(posedge clk); #1;
      axi.ARID = id; axi.ARADDR = addr; axi.ARLEN = len;
      axi.ARSIZE = size; axi.ARBURST = burst; axi.ARVALID = 1'b1;
      @(negedge clk);
      while (!axi.ARREADY && n < 200) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (!axi.ARREADY) begin
         errors++;
         $display("FAIL ar_accept got ARREADY=0 after %0d cycles expected 1", n);
         axi.ARVALID = 1'b0;
         return;
      end
      err = (size != 3'd0) || (burst == 2'b11);
      for (int k = 0; k <= int'(len); k++) begin
         b.id   = id;
         b.data = mem[beat_addr(addr, len, err ? 2'b01 : burst, k)];
         b.last = (k == int'(len));
         b.resp = err ? 2'b10 : 2'b00;
         exp_q.push_back(b);
      end
      @(posedge clk); #1;
      axi.ARVALID = 1'b0;
      axi.ARID = 4'($urandom); axi.ARADDR = 16'($urandom); axi.ARLEN = 8'($urandom);
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !axi.RVALID && axi.ARREADY) && n < 1000) begin
         @(negedge clk); #1;
         n++;
      end
      checks++;
      if (n >= 1000) begin
         errors++;
         $display("FAIL %s drain got %0d beats pending expected 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   // assumed to be called just after a rising edge
   task automatic pulse_reset();
      #3;
      rst = 1'b1;
      exp_q.delete();
      #1;
      check("rst_rvalid", axi.RVALID, 0);
      check("rst_arready", axi.ARREADY, 1);
      check("rst_rlast", axi.RLAST, 0);
      check("rst_rid", axi.RID, 0);
      check("rst_rdata", axi.RDATA, 0);
      check("rst_rresp", axi.RRESP, 0);
      check("rst_raddr", raddr, 0);
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
   endtask

   // back-pressure generator: 0 always ready, 1 random, 2 pattern 1,0,0
   initial begin
      int tog;
      tog = 0;
      axi.RREADY = 1'b0;
      forever begin
         @(posedge clk); #1;
         case (rr_mode)
            0: axi.RREADY = 1'b1;
            1: axi.RREADY = 1'($urandom_range(0, 1));
            2: begin
               axi.RREADY = (tog % 3 == 0);
               tog++;
            end
            default: axi.RREADY = 1'b1;
         endcase
      end
   end

   // R monitor: scoreboard every accepted beat, check stability when stalled
   initial begin
      beat_t cur, prev, e;
      logic  have_prev, prev_v, prev_r;
      have_prev = 1'b0; prev_v = 1'b0; prev_r = 1'b0;
      forever begin
         @(negedge clk);
         cur.id = axi.RID; cur.data = axi.RDATA; cur.last = axi.RLAST; cur.resp = axi.RRESP;
         if (rst) begin
            have_prev = 1'b0;
         end else begin
            if (have_prev && prev_v && !prev_r) begin
               checks++;
               if (!(axi.RVALID && cur == prev)) begin
                  errors++;
                  $display("FAIL hold_stable got v=%0b id=%0h data=%0h last=%0b resp=%0h expected v=1 id=%0h data=%0h last=%0b resp=%0h",
                           axi.RVALID, cur.id, cur.data, cur.last, cur.resp, prev.id, prev.data, prev.last, prev.resp);
               end
            end
            if (axi.RVALID && axi.RREADY) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat got id=%0h data=%0h expected no beat", cur.id, cur.data);
               end else begin
                  e = exp_q.pop_front();
                  if (cur != e) begin
                     errors++;
                     $display("FAIL beat got id=%0h data=%0h last=%0b resp=%0h expected id=%0h data=%0h last=%0b resp=%0h",
                              cur.id, cur.data, cur.last, cur.resp, e.id, e.data, e.last, e.resp);
                  end
               end
               got_q.push_back(cur);
               beats_acc++;
            end
            have_prev = 1'b1;
            prev_v = axi.RVALID; prev_r = axi.RREADY; prev = cur;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] wexp [4];
      int          g0, n;
      logic [1:0]  bt;
      logic [7:0]  ln;

      for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 4; i++) mem[16'h0010 + i] = 8'hA0 + 8'(i);

      rst = 1'b1;
      axi.ARVALID = 1'b0; axi.ARID = 4'd0; axi.ARADDR = 16'd0;
      axi.ARLEN = 8'd0; axi.ARSIZE = 3'd0; axi.ARBURST = 2'b01;
      #1;
      check("reset_arready", axi.ARREADY, 1);
      check("reset_rvalid", axi.RVALID, 0);
      check("reset_rlast", axi.RLAST, 0);
      check("reset_rid", axi.RID, 0);
      check("reset_rdata", axi.RDATA, 0);
      check("reset_rresp", axi.RRESP, 0);
      check("reset_raddr", raddr, 0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      rr_mode = 0;
      repeat (2) @(posedge clk);

      // INCR at 0x0010, len 3: latency and data order
      ar_send(4'd1, 16'h0010, 8'd3, 3'd0, 2'b01);
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) check("incr_raddr", raddr, 32'h10 + 32'(k - 1));
         if (k == 2) check("incr_rvalid_early", axi.RVALID, 0);
         if (k >= 3) begin
            check("incr_rvalid", axi.RVALID, 1);
            check("incr_rdata", axi.RDATA, 32'hA0 + 32'(k - 3));
            check("incr_rlast", axi.RLAST, (k == 6) ? 1 : 0);
            check("incr_rresp", axi.RRESP, 0);
         end
      end
      wait_idle("incr");

      // WRAP at 0x0006, len 3
      wexp = '{16'h0006, 16'h0007, 16'h0004, 16'h0005};
      ar_send(4'd2, 16'h0006, 8'd3, 3'd0, 2'b10);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("wrap_raddr", raddr, wexp[k]);
      end
      wait_idle("wrap");

      // INCR across the top of the address space
      ar_send(4'd6, 16'hFFFF, 8'd1, 3'd0, 2'b01);
      @(negedge clk); check("rollover_raddr0", raddr, 16'hFFFF);
      @(negedge clk); check("rollover_raddr1", raddr, 16'h0000);
      wait_idle("rollover");

      // back-to-back bursts
      g0 = got_q.size();
      ar_send(4'd3, 16'h0030, 8'd1, 3'd0, 2'b01);
      ar_send(4'd5, 16'h0040, 8'd0, 3'd0, 2'b01);
      wait_idle("b2b");
      check("b2b_count", got_q.size() - g0, 3);
      if (got_q.size() - g0 == 3) begin
         check("b2b_id0", got_q[g0].id, 3);   check("b2b_last0", got_q[g0].last, 0);
         check("b2b_id1", got_q[g0+1].id, 3); check("b2b_last1", got_q[g0+1].last, 1);
         check("b2b_id2", got_q[g0+2].id, 5); check("b2b_last2", got_q[g0+2].last, 1);
      end

      // error burst: size != 1 byte
      g0 = got_q.size();
      ar_send(4'd7, 16'h0050, 8'd1, 3'd1, 2'b01);
      wait_idle("err");
      check("err_count", got_q.size() - g0, 2);
      if (got_q.size() - g0 == 2) begin
         check("err_resp0", got_q[g0].resp, 2'b10);   check("err_last0", got_q[g0].last, 0);
         check("err_resp1", got_q[g0+1].resp, 2'b10); check("err_last1", got_q[g0+1].last, 1);
      end

      // len 7 with RREADY 1,0,0 pattern
      rr_mode = 2;
      g0 = got_q.size();
      ar_send(4'd4, 16'h0200, 8'd7, 3'd0, 2'b01);
      wait_idle("stall");
      check("stall_count", got_q.size() - g0, 8);
      if (got_q.size() - g0 == 8)
         for (int i = 0; i < 8; i++) check("stall_data", got_q[g0+i].data, mem[16'h0200 + 16'(i)]);

      // randomized bursts with random back-pressure
      rr_mode = 1;
      for (int t = 0; t < 60; t++) begin
         bt = 2'($urandom_range(0, 3));
         ln = (bt == 2'b10) ? 8'((1 << $urandom_range(1, 4)) - 1) : 8'($urandom_range(0, 15));
         ar_send(4'($urandom), 16'($urandom), ln,
                 ($urandom_range(0, 7) == 0) ? 3'd2 : 3'd0, bt);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_idle("random");

      // reset after the 2nd beat of a len 7 burst
      rr_mode = 0;
      repeat (2) @(posedge clk);
      g0 = beats_acc;
      ar_send(4'd9, 16'h0300, 8'd7, 3'd0, 2'b01);
      n = 0;
      while (beats_acc < g0 + 2 && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("midrst_two_beats", beats_acc - g0, 2);
      pulse_reset();
      g0 = got_q.size();
      repeat (6) @(negedge clk);
      check("midrst_no_stale", got_q.size() - g0, 0);
      ar_send(4'd2, 16'h0020, 8'd0, 3'd0, 2'b01);
      wait_idle("midrst");
      check("midrst_count", got_q.size() - g0, 1);
      if (got_q.size() - g0 == 1) begin
         check("midrst_data", got_q[g0].data, mem[16'h0020]);
         check("midrst_last", got_q[g0].last, 1);
         check("midrst_id", got_q[g0].id, 2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
